// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed scan controller for a common-anode 7-seg display.
// Digit frames update atomically at frame boundaries via a load/ack handshake.
module seg_scan_ctrl #(
   parameter int NUM_DIGITS  = 4,
   parameter int REFRESH_DIV = 100000,
   parameter int DIV_W       = 17
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    blank_lz,
   input  logic                    load,
   input  logic [4*NUM_DIGITS-1:0] value_in,
   output logic [3:0]              bcd_out,
   output logic [NUM_DIGITS-1:0]   an,
   output logic                    pending,
   output logic                    upd_ack,
   output logic                    frame_tick
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
   localparam logic [IW-1:0] IDX_MAX = IW'(NUM_DIGITS - 1);

   typedef enum logic {
      OFF,
      SCAN
   } state_t;

   state_t state_q, state_d;

   logic [DIV_W-1:0]        div_q, div_d;
   logic [IW-1:0]           idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] disp_q, shadow_q;
   logic                    pending_q, commit_q, ack_q;
   logic [NUM_DIGITS-1:0]   an_q, an_d;
   logic [3:0]              bcd_q, bcd_d;
   logic [3:0]              dig [NUM_DIGITS];
   logic [NUM_DIGITS-1:0]   zf;
   logic                    allz, blank, tick, wrap;

   assign wrap = (div_q == DIV_MAX);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= OFF;
         div_q   <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d = en ? SCAN : OFF;
      div_d   = div_q;
      idx_d   = idx_q;
      tick    = 1'b0;
      unique case (state_q)
         OFF: begin
         end
         SCAN: begin
            if (wrap) begin
               div_d = '0;
               tick  = (idx_q == IDX_MAX);
               if (idx_q == IDX_MAX)
                  idx_d = '0;
               else
                  idx_d = idx_q + 1'b1;
            end else begin
               div_d = div_q + 1'b1;
            end
         end
      endcase
   end

   // zf[k]: digit k and every digit above it are zero
   always_comb begin
      allz = 1'b1;
      zf   = '0;
      for (int k = 0; k < NUM_DIGITS; k++)
         dig[k] = disp_q[4*k +: 4];
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         allz  = allz && (dig[k] == 4'd0);
         zf[k] = allz;
      end
      blank = (dig[idx_q] > 4'd9) ||
              (blank_lz && (idx_q != '0) && zf[idx_q]);
      an_d  = '1;
      bcd_d = bcd_q;
      if (state_q == SCAN) begin
         bcd_d = dig[idx_q];
         for (int k = 0; k < NUM_DIGITS; k++)
            if (IW'(k) == idx_q)
               an_d[k] = blank;
      end
   end

   // commit at a boundary reads the old shadow even if load recaptures
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         an_q      <= '1;
         bcd_q     <= '0;
         disp_q    <= '0;
         shadow_q  <= '0;
         pending_q <= 1'b0;
         commit_q  <= 1'b0;
         ack_q     <= 1'b0;
      end else begin
         an_q     <= an_d;
         bcd_q    <= bcd_d;
         commit_q <= 1'b0;
         ack_q    <= commit_q;
         if (tick && pending_q) begin
            disp_q    <= shadow_q;
            pending_q <= 1'b0;
            commit_q  <= 1'b1;
         end
         if (load) begin
            shadow_q  <= value_in;
            pending_q <= 1'b1;
         end
      end
   end

   assign an         = an_q;
   assign bcd_out    = bcd_q;
   assign pending    = pending_q;
   assign upd_ack    = ack_q;
   assign frame_tick = tick;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl.
// Four digits, REFRESH_DIV=4, so a frame is 16 cycles.
module tb_seg_scan_ctrl;

   localparam int N  = 4;
   localparam int RD = 4;

   logic        clk = 1'b0;
   logic        rst_n, en, blank_lz, load;
   logic [15:0] value_in;
   logic [3:0]  bcd_out, an;
   logic        pending, upd_ack, frame_tick;

   int ncheck = 0;
   int npass  = 0;

   seg_scan_ctrl #(
      .NUM_DIGITS (N),
      .REFRESH_DIV(RD),
      .DIV_W      (3)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .blank_lz  (blank_lz),
      .load      (load),
      .value_in  (value_in),
      .bcd_out   (bcd_out),
      .an        (an),
      .pending   (pending),
      .upd_ack   (upd_ack),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      ncheck++;
      if (got === exp)
         npass++;
      else
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   // called on the cycle digit 0 of a frame first appears
   task automatic expect_frame(input logic [15:0] val,
                               input logic [3:0]  mask,
                               input logic        ack);
      logic [3:0] one;
      logic [3:0] ea;
      one = 4'b0001;
      for (int i = 0; i < 16; i++) begin
         int d;
         d  = i / 4;
         ea = mask[d] ? 4'hF : ~(one << d);
         check("frm_an", 32'(an), 32'(ea));
         check("frm_bcd", 32'(bcd_out), 32'(val[4*d +: 4]));
         check("frm_tick", 32'(frame_tick), 32'(i == 14));
         check("frm_ack", 32'(upd_ack), 32'(ack && i == 0));
         step(1);
      end
   endtask

   task automatic wait_tick();
      int n;
      n = 0;
      while (frame_tick !== 1'b1 && n < 64) begin
         step(1);
         n++;
      end
      check("tick_seen", 32'(frame_tick), 32'd1);
   endtask

   task automatic load_val(input logic [15:0] v);
      load     = 1'b1;
      value_in = v;
      step(1);
      load     = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1);
   end

   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      blank_lz = 1'b0;
      load     = 1'b0;
      value_in = '0;
      step(3);
      check("rst_an", 32'(an), 32'hF);
      check("rst_bcd", 32'(bcd_out), 32'd0);
      check("rst_pend", 32'(pending), 32'd0);
      check("rst_ack", 32'(upd_ack), 32'd0);
      check("rst_tick", 32'(frame_tick), 32'd0);

      // load while OFF, then enable
      rst_n = 1'b1;
      load_val(16'h3210);
      check("ld_pend", 32'(pending), 32'd1);
      check("off_an", 32'(an), 32'hF);
      en = 1'b1;
      step(1);
      check("en_e1_an", 32'(an), 32'hF);
      step(1);
      check("en_e2_an", 32'(an), 32'hE);
      check("en_e2_bcd", 32'(bcd_out), 32'd0);
      wait_tick();
      check("c_pend", 32'(pending), 32'd1);
      step(1);
      check("c1_ack", 32'(upd_ack), 32'd0);
      check("c1_pend", 32'(pending), 32'd0);
      step(1);
      expect_frame(16'h3210, 4'b0000, 1'b1);

      // mid-frame load
      step(5);
      load_val(16'h0123);
      check("hs_pend", 32'(pending), 32'd1);
      wait_tick();
      check("hs_old", 32'(bcd_out), 32'd3);
      step(1);
      check("hs_ack0", 32'(upd_ack), 32'd0);
      step(1);
      expect_frame(16'h0123, 4'b0000, 1'b1);

      // back-to-back loads
      load_val(16'h1111);
      load_val(16'h2222);
      wait_tick();
      step(2);
      expect_frame(16'h2222, 4'b0000, 1'b1);

      // load on the boundary cycle
      load_val(16'h4444);
      wait_tick();
      load_val(16'h3333);
      check("bl_pend1", 32'(pending), 32'd1);
      check("bl_ack0", 32'(upd_ack), 32'd0);
      step(1);
      check("bl_pend2", 32'(pending), 32'd1);
      expect_frame(16'h4444, 4'b0000, 1'b1);
      check("bl_pend3", 32'(pending), 32'd0);
      expect_frame(16'h3333, 4'b0000, 1'b1);

      // leading-zero and invalid-code blanking
      blank_lz = 1'b1;
      load_val(16'h0005);
      wait_tick();
      step(2);
      expect_frame(16'h0005, 4'b1110, 1'b1);
      load_val(16'h0000);
      wait_tick();
      step(2);
      expect_frame(16'h0000, 4'b1110, 1'b1);
      load_val(16'h0A05);
      wait_tick();
      step(2);
      expect_frame(16'h0A05, 4'b1100, 1'b1);

      // enable freeze mid digit 2
      blank_lz = 1'b0;
      load_val(16'h3210);
      wait_tick();
      step(2);
      check("fz_ack", 32'(upd_ack), 32'd1);
      step(9);
      check("fz_pre", 32'(an), 32'hB);
      en = 1'b0;
      step(1);
      check("fz_hold", 32'(an), 32'hB);
      step(1);
      check("fz_off", 32'(an), 32'hF);
      check("fz_bcd", 32'(bcd_out), 32'd2);
      step(8);
      check("fz_off2", 32'(an), 32'hF);
      check("fz_tick", 32'(frame_tick), 32'd0);
      en = 1'b1;
      step(1);
      check("fz_re1", 32'(an), 32'hF);
      step(1);
      check("fz_re2_an", 32'(an), 32'hB);
      check("fz_re2_bcd", 32'(bcd_out), 32'd2);
      step(1);
      check("fz_d3_an", 32'(an), 32'h7);
      check("fz_d3_bcd", 32'(bcd_out), 32'd3);
      step(1);
      check("fz_notick", 32'(frame_tick), 32'd0);
      step(1);
      check("fz_tick2", 32'(frame_tick), 32'd1);
      step(2);
      check("fz_d0_an", 32'(an), 32'hE);
      check("fz_d0_bcd", 32'(bcd_out), 32'd0);

      // reset with a value pending
      load_val(16'h9999);
      check("rr_pend", 32'(pending), 32'd1);
      rst_n = 1'b0;
      step(1);
      check("rr_an", 32'(an), 32'hF);
      check("rr_bcd", 32'(bcd_out), 32'd0);
      check("rr_pend0", 32'(pending), 32'd0);
      check("rr_ack", 32'(upd_ack), 32'd0);
      check("rr_tick", 32'(frame_tick), 32'd0);
      rst_n = 1'b1;
      step(1);
      check("rr_e1_an", 32'(an), 32'hF);
      step(1);
      check("rr_e2_an", 32'(an), 32'hE);
      check("rr_e2_bcd", 32'(bcd_out), 32'd0);
      wait_tick();
      step(1);
      check("rr_noack1", 32'(upd_ack), 32'd0);
      step(1);
      expect_frame(16'h0000, 4'b0000, 1'b0);

      $display("%0d/%0d checks passed", npass, ncheck);
      $finish;
   end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

Time-multiplexed scan controller for the board's 4-digit common-anode seven-segment display. It owns a frame of BCD digits, sequences one digit at a time onto the shared single-digit BCD-to-segment decoder, and drives the active-low anode enables. New values are accepted through a load/ack handshake and committed only at a frame boundary, so a frame never shows a mix of old and new digits. It sits between the value-producing logic and the existing `bcd` decoder instance.

## Interface
- `NUM_DIGITS`, 4: number of multiplexed digits. Supported range is 2..8.
- `REFRESH_DIV`, 100000: clock cycles each digit is held (1 ms at 100 MHz). Must be ≥ 2.
- `DIV_W`, 17: width of the refresh divider. Must satisfy `2**DIV_W > REFRESH_DIV`.

Ports (clock and reset first):
- `clk` in 1: single system clock; all state updates on the rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `en` in 1: scan enable; 0 blanks all digits and freezes scanning.
- `blank_lz` in 1: 1 enables leading-zero blanking.
- `load` in 1: single-cycle request to capture `value_in`.
- `value_in` in 4*NUM_DIGITS: packed BCD digits; digit 0 (least significant) is in bits [3:0].
- `bcd_out` out 4: BCD code of the active digit; feeds the shared decoder.
- `an` out NUM_DIGITS: anode enables, active-low; at most one bit is low at a time.
- `pending` out 1: a captured value is waiting for a frame boundary.
- `upd_ack` out 1: one-cycle pulse when a captured value is committed to the display.
- `frame_tick` out 1: one-cycle pulse on the last cycle of the last digit of each frame.

## Operation
- Reset (`rst_n`=0 at an edge) sets:
  - `an` to all 1s; `bcd_out`, `pending`, `upd_ack` and `frame_tick` to 0.
  - Divider `div`=0, digit index `idx`=0.
  - Display register `disp`=0 and shadow register `shadow`=0.
- Reset has priority over every other input. A reset mid-frame or mid-handshake discards the pending value with no ack.
- Scan state machine has two states:
  - OFF: entered from reset, or whenever `en`=0. Holds `an`=all 1s, and `div` and `idx` hold their values.
  - SCAN: entered when `en`=1. Leaving SCAN (`en`→0) takes effect at the next edge. Returning to SCAN resumes from the held `div`/`idx`.
- Divider in SCAN:
  - `div` counts 0..REFRESH_DIV-1.
  - At `div`=REFRESH_DIV-1, `div` returns to 0 and `idx` advances, wrapping NUM_DIGITS-1 → 0.
- `frame_tick` is 1 in the cycle where `div`=REFRESH_DIV-1 and `idx`=NUM_DIGITS-1, while in SCAN.
- Load handshake:
  - `load`=1 captures `value_in` into `shadow` and sets `pending`.
  - A `load` while `pending`=1 overwrites `shadow` (last value wins); only one ack is given.
  - At a frame boundary with `pending`=1: `disp` takes `shadow`, `pending` clears, and `upd_ack` pulses on the next cycle.
  - `load` in the same cycle as a boundary: the old `shadow` is committed and acked, then the new value is captured and `pending` stays 1.
  - `load` is accepted in OFF as well, but commits only at a SCAN frame boundary.
- Digit blanking (anode held high for that digit slot):
  - The digit's BCD code is greater than 9.
  - Or `blank_lz`=1, the digit index is above 0, and this digit and every higher digit are 0.
  - Digit 0 is never blanked by leading-zero suppression.
- `bcd_out` shows `disp[4*idx+3:4*idx]` even when the digit is blanked.

## Timing
- `an` and `bcd_out` are registered from `idx`/`disp`/`en`, so they lag `idx` by one cycle.
- After reset release with `en`=1:
  - The first edge enters SCAN.
  - The second edge drives `an`=~(1<<0) together with digit 0.
- Each digit is displayed for exactly REFRESH_DIV cycles. A full frame is NUM_DIGITS*REFRESH_DIV cycles.
- A committed value first appears on `an`/`bcd_out` 2 cycles after the `frame_tick` cycle, at digit 0, in the same cycle as `upd_ack`.
- Worst-case load-to-display latency is NUM_DIGITS*REFRESH_DIV+2 cycles.
- `en`=0 forces `an`=all 1s one cycle later. `bcd_out` holds its last value.

## Test plan
- **Reset and scan**: reset, then `en`=1, REFRESH_DIV=4, `disp`=0x3210 → `an` sequence 1110, 1101, 1011, 0111 with 4 cycles each and `bcd_out` 0, 1, 2, 3; `frame_tick` every 16 cycles.
- **Handshake timing**: `load` with 0x0123 mid-frame → `pending` goes to 1; `upd_ack` pulses 2 cycles after the next `frame_tick`; that frame shows 3, 2, 1, 0 starting at digit 0; no partial update appears.
- **Overwrite and boundary load**: back-to-back `load` 0x1111 then 0x2222 → a single ack and 0x2222 displayed. A `load` 0x3333 in the `frame_tick` cycle → the pending value is acked, `pending` stays 1, and 0x3333 commits one frame later.
- **Leading-zero blanking**: `blank_lz`=1 with 0x0005 → only digit 0 lit; with 0x0000 → digit 0 lit showing 0; with 0x0A05 → digit 2 blanked (invalid code) and digit 3 blanked (leading zero), digit 1 lit.
- **Enable freeze**: `en` dropped mid-digit 2 for 10 cycles → `an`=1111 one cycle later; on re-enable, scanning resumes at digit 2 for the remaining divider count.
- **Reset mid-frame**: `rst_n`=0 for one cycle while `pending`=1 → all outputs return to reset values, no `upd_ack`, and `disp`=0.
